// File: rtl/sized_data_memory.sv
// Byte-addressed little-endian data memory with sized, sign/zero-extending loads.
// Loads complete READ_LATENCY edges after acceptance; illegal requests raise a one-cycle error.
module sized_data_memory #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 48,
  parameter int unsigned DEPTH_BYTES  = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memWrite,
  input  logic                  memRead,
  input  logic [1:0]            size,
  input  logic                  unsignedLoad,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readValid,
  output logic                  ready,
  output logic                  error
);

  localparam int unsigned IdxW    = $clog2(DEPTH_BYTES);
  localparam int unsigned AddrExtW = ADDR_WIDTH + 1;
  localparam logic [1:0]  CntInit = 2'(READ_LATENCY - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state_q;
  logic [1:0]            cnt_q;
  logic [DATA_WIDTH-1:0] pend_q;
  logic [7:0]            mem_q [DEPTH_BYTES];

  logic [3:0]            n_bytes;
  logic [7:0]            byte_en;
  logic [IdxW-1:0]       idx;
  logic [AddrExtW-1:0]   end_addr;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  accept;
  logic                  bad;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rej;
  logic [DATA_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] rd_ext;

  assign ready = (state_q == StIdle);
  assign idx   = address[IdxW-1:0];

  always_comb begin
    n_bytes = 4'd1;
    byte_en = 8'h01;
    unique case (size)
      2'b00: begin n_bytes = 4'd1; byte_en = 8'h01; end
      2'b01: begin n_bytes = 4'd2; byte_en = 8'h03; end
      2'b10: begin n_bytes = 4'd4; byte_en = 8'h0F; end
      2'b11: begin n_bytes = 4'd8; byte_en = 8'hFF; end
    endcase
  end

  // Range check uses one extra bit so addresses near the top of the space cannot wrap.
  always_comb begin
    misaligned   = (address[2:0] & 3'(n_bytes - 4'd1)) != 3'd0;
    end_addr     = {1'b0, address} + AddrExtW'(n_bytes);
    out_of_range = end_addr > AddrExtW'(DEPTH_BYTES);
    accept       = ready & ~rst & (memWrite | memRead);
    bad          = (memWrite & memRead) | misaligned | out_of_range;
    wr_ok        = accept & memWrite & ~bad;
    rd_ok        = accept & memRead & ~bad;
    rej          = accept & bad;
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      raw[8*i +: 8] = mem_q[idx + IdxW'(i)];
    end
  end

  always_comb begin
    rd_ext = raw;
    unique case (size)
      2'b00: rd_ext = unsignedLoad ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
      2'b01: rd_ext = unsignedLoad ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10: rd_ext = unsignedLoad ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      2'b11: rd_ext = raw;
    endcase
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en[i]) begin
          mem_q[idx + IdxW'(i)] <= writeData[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      pend_q    <= '0;
      readData  <= '0;
      readValid <= 1'b0;
      error     <= 1'b0;
    end else begin
      readValid <= 1'b0;
      error     <= rej;
      unique case (state_q)
        StIdle: begin
          if (rd_ok) begin
            pend_q  <= rd_ext;
            cnt_q   <= CntInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 2'd0) begin
            readData  <= pend_q;
            readValid <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// Scoreboard bench for sized_data_memory: expected loads are queued at issue and
// compared, with their arrival cycle, when readValid pulses.
module tb_sized_data_memory;

  localparam int unsigned Lat   = 3;
  localparam int unsigned Depth = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memWrite = 1'b0;
  logic        memRead = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsignedLoad = 1'b0;
  logic [47:0] address = '0;
  logic [63:0] writeData = '0;
  logic [63:0] readData;
  logic        readValid;
  logic        ready;
  logic        error;

  typedef struct {
    logic [63:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [63:0] last_rd = '0;

  sized_data_memory #(
    .DATA_WIDTH  (64),
    .ADDR_WIDTH  (48),
    .DEPTH_BYTES (Depth),
    .READ_LATENCY(Lat)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .memWrite    (memWrite),
    .memRead     (memRead),
    .size        (size),
    .unsignedLoad(unsignedLoad),
    .address     (address),
    .writeData   (writeData),
    .readData    (readData),
    .readValid   (readValid),
    .ready       (ready),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Monitor: every readValid must match the oldest queued expectation, on its due cycle.
  always @(negedge clk) begin
    if (!rst && readValid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rd_data", readData, e.data);
        check("rd_cycle", 64'(cyc), 64'(e.due));
        check("rd_ready", 64'(ready), 64'd1);
        last_rd = e.data;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic do_write(input logic [1:0] sz, input logic [47:0] a, input logic [63:0] d);
    wait_ready();
    memWrite = 1'b1; size = sz; address = a; writeData = d;
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    check("wr_error", 64'(error), 64'd0);
    check("wr_ready", 64'(ready), 64'd1);
  endtask

  task automatic issue_read(input logic [1:0] sz, input logic uns, input logic [47:0] a,
                            input logic [63:0] exp);
    exp_t e;
    wait_ready();
    memRead = 1'b1; size = sz; unsignedLoad = uns; address = a;
    e.data = exp;
    e.due  = cyc + 1 + Lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    memRead = 1'b0;
    check("rd_accept_error", 64'(error), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_read(input logic [1:0] sz, input logic uns, input logic [47:0] a,
                         input logic [63:0] exp);
    issue_read(sz, uns, a, exp);
    drain();
  endtask

  task automatic do_reject(input string tag, input logic we, input logic re,
                           input logic [1:0] sz, input logic [47:0] a, input logic [63:0] d);
    wait_ready();
    memWrite = we; memRead = re; size = sz; address = a; writeData = d;
    @(posedge clk);
    #1;
    memWrite = 1'b0; memRead = 1'b0;
    check({tag, "_error"}, 64'(error), 64'd1);
    check({tag, "_ready"}, 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_error_clr"}, 64'(error), 64'd0);
    check({tag, "_rd_hold"}, readData, last_rd);
  endtask

  initial begin
    #1;
    check("rst_readData", readData, 64'd0);
    check("rst_readValid", 64'(readValid), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_write(2'b11, 48'h10, 64'h8877665544332211);
    do_read(2'b00, 1'b0, 48'h17, 64'hFFFFFFFFFFFFFF88);
    do_read(2'b01, 1'b1, 48'h12, 64'h0000000000004433);
    do_read(2'b10, 1'b0, 48'h14, 64'hFFFFFFFF88776655);
    do_read(2'b00, 1'b1, 48'h17, 64'h0000000000000088);
    do_read(2'b01, 1'b0, 48'h16, 64'hFFFFFFFFFFFF8877);
    do_read(2'b10, 1'b1, 48'h14, 64'h0000000088776655);
    do_read(2'b00, 1'b0, 48'h11, 64'h0000000000000022);

    do_write(2'b00, 48'h11, 64'hDEADBEEFCAFE12AB);
    do_read(2'b11, 1'b1, 48'h10, 64'h887766554433AB11);

    do_write(2'b11, 48'h00, 64'h0123456789ABCDEF);
    do_write(2'b11, 48'h08, 64'hFEDCBA9876543210);
    do_write(2'b01, 48'h3FE, 64'h000000000000A55A);
    do_reject("mis_wr", 1'b1, 1'b0, 2'b10, 48'h06, 64'hFFFFFFFFFFFFFFFF);
    do_reject("oor_rd", 1'b0, 1'b1, 2'b00, 48'(Depth), 64'd0);
    do_reject("oor_wr", 1'b1, 1'b0, 2'b10, 48'h3FE, 64'h0000000011111111);
    do_reject("wrap_rd", 1'b0, 1'b1, 2'b11, 48'hFFFFFFFFFFF8, 64'd0);
    do_reject("both", 1'b1, 1'b1, 2'b11, 48'h00, 64'h1111111111111111);
    do_read(2'b11, 1'b1, 48'h00, 64'h0123456789ABCDEF);
    do_read(2'b11, 1'b1, 48'h08, 64'hFEDCBA9876543210);
    do_read(2'b01, 1'b1, 48'h3FE, 64'h000000000000A55A);

    // Back-to-back: second read is accepted in the first read's readValid cycle.
    issue_read(2'b10, 1'b1, 48'h00, 64'h0000000089ABCDEF);
    issue_read(2'b10, 1'b0, 48'h0C, 64'hFFFFFFFFFEDCBA98);
    drain();

    // Abort an in-flight read with reset; a write during WAIT must be ignored.
    do_write(2'b11, 48'h20, 64'h1122334455667788);
    wait_ready();
    memRead = 1'b1; size = 2'b11; address = 48'h20;
    @(posedge clk);
    #1;
    memRead = 1'b0;
    check("abort_busy", 64'(ready), 64'd0);
    memWrite = 1'b1; address = 48'h20; writeData = 64'h0BADBADBADBADBAD;
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    check("ignored_wr_error", 64'(error), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_readData", readData, 64'd0);
    check("abort_readValid", 64'(readValid), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_error", 64'(error), 64'd0);
    last_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (Lat + 3) @(negedge clk);
    do_read(2'b11, 1'b1, 48'h20, 64'h1122334455667788);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
